// File: rtl/pwm_ramp_ctrl_pkg.sv
// Shared types and constants for the PWM ramp sequencer and the PWM core.
// Optional fault handling is built in when PWM_RAMP_FAULT_EN is defined.
package pwm_pkg;

  localparam int PWM_DUTY_W = 8;
  localparam int PWM_DIV_W  = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SLEW  = 3'd1,
    HOLD  = 3'd2,
    STOP  = 3'd3,
    FAULT = 3'd4
  } pwm_ramp_state_t;

  // FAULT shares the external code of STOP; the 2-bit debug port has no spare value.
  function automatic logic [1:0] state_code(input pwm_ramp_state_t s);
    logic [2:0] v;
    v = s;
    if (s == FAULT) return 2'd3;
    return v[1:0];
  endfunction

endpackage

// File: rtl/pwm_ramp_ctrl_if.sv
// Signal bundle between the user IO/config side and the ramp sequencer.
// Fault signals exist only when PWM_RAMP_FAULT_EN is defined.
interface pwm_ramp_ctrl_if #(
  parameter int DUTY_W = 8,
  parameter int DIV_W  = 16
);
  // All requests are levels sampled on every rising clock edge; there is no
  // valid/ready handshake. stop has priority over start in every state.
  logic              start;
  logic              stop;
  logic [DUTY_W-1:0] target;
  logic [DUTY_W-1:0] step;
  logic [DIV_W-1:0]  div;
  logic              en;
  logic [DUTY_W-1:0] duty;
  logic              busy;
  logic              at_target;
  logic [1:0]        state;
`ifdef PWM_RAMP_FAULT_EN
  logic              fault;
  logic              fault_clr;
  logic              fault_flag;
`endif

  modport master (
    output start, stop, target, step, div,
`ifdef PWM_RAMP_FAULT_EN
    output fault, fault_clr,
    input  fault_flag,
`endif
    input  en, duty, busy, at_target, state
  );

  modport slave (
    input  start, stop, target, step, div,
`ifdef PWM_RAMP_FAULT_EN
    input  fault, fault_clr,
    output fault_flag,
`endif
    output en, duty, busy, at_target, state
  );

endinterface

// File: rtl/pwm_ramp_ctrl_tick.sv
// Step-interval prescaler: tick fires when the count equals div, then restarts.
module pwm_ramp_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // div is compared live; a shrinking div lets the count run to wrap.
  assign tick  = (cnt_q == div);
  assign cnt_d = (clr || tick) ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Soft-start / soft-stop / rate-limited duty sequencer for the 3-phase PWM core.
// Define PWM_RAMP_FAULT_EN to add the synchronised fault input and FAULT state.
module pwm_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int DUTY_W = PWM_DUTY_W,
  parameter int DIV_W  = PWM_DIV_W
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic [DUTY_W-1:0] target_i,
  input  logic [DUTY_W-1:0] step_i,
  input  logic [DIV_W-1:0]  div_i,
`ifdef PWM_RAMP_FAULT_EN
  input  logic              fault_i,
  input  logic              fault_clr_i,
  output logic              fault_o,
`endif
  output logic              en_o,
  output logic [DUTY_W-1:0] duty_o,
  output logic              busy_o,
  output logic              at_target_o,
  output logic [1:0]        state_o
);

  pwm_ramp_state_t   state_q, state_d;
  logic              en_q, en_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              busy_q, busy_d;
  logic              at_q, at_d;
  logic              tick, cnt_clr, run_req;
  logic [DUTY_W-1:0] step_eff, slew_next, stop_next;
  logic [DUTY_W:0]   up_sum, dn_diff;

`ifdef PWM_RAMP_FAULT_EN
  logic fault_meta_q, fault_sync_q, fault_q, fault_d;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      fault_meta_q <= 1'b0;
      fault_sync_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      fault_meta_q <= fault_i;
      fault_sync_q <= fault_meta_q;
      fault_q      <= fault_d;
    end
  end

  assign fault_o = fault_q;
`endif

  assign run_req  = start_i & ~stop_i;
  assign step_eff = (step_i == '0) ? DUTY_W'(1) : step_i;
  assign up_sum   = {1'b0, duty_q} + {1'b0, step_eff};
  assign dn_diff  = {1'b0, duty_q} - {1'b0, step_eff};

  // Extra MSB catches overflow/underflow so steps clamp instead of wrapping.
  always_comb begin
    slew_next = duty_q;
    if (duty_q < target_i) begin
      slew_next = (up_sum >= {1'b0, target_i}) ? target_i : up_sum[DUTY_W-1:0];
    end else if (duty_q > target_i) begin
      slew_next = (dn_diff[DUTY_W] || (dn_diff[DUTY_W-1:0] < target_i))
                  ? target_i : dn_diff[DUTY_W-1:0];
    end
    stop_next = dn_diff[DUTY_W] ? '0 : dn_diff[DUTY_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    en_d    = en_q;
    unique case (state_q)
      IDLE: begin
        en_d   = 1'b0;
        duty_d = '0;
        if (run_req) begin
          state_d = SLEW;
          en_d    = 1'b1;
        end
      end
      SLEW: begin
        en_d = 1'b1;
        if (stop_i) begin
          state_d = STOP;
        end else begin
          if (tick) duty_d = slew_next;
          if (duty_d == target_i) state_d = HOLD;
        end
      end
      HOLD: begin
        en_d = 1'b1;
        if (stop_i)                  state_d = STOP;
        else if (target_i != duty_q) state_d = SLEW;
      end
      STOP: begin
        en_d = 1'b1;
        if (run_req) begin
          state_d = SLEW;
        end else begin
          if (tick) duty_d = stop_next;
          if (duty_d == '0) begin
            state_d = IDLE;
            en_d    = 1'b0;
          end
        end
      end
      FAULT: begin
        en_d   = 1'b0;
        duty_d = '0;
`ifdef PWM_RAMP_FAULT_EN
        if (fault_clr_i && !fault_sync_q) state_d = IDLE;
`else
        state_d = IDLE;
`endif
      end
      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
        duty_d  = '0;
      end
    endcase
`ifdef PWM_RAMP_FAULT_EN
    if (fault_sync_q) begin
      state_d = FAULT;
      en_d    = 1'b0;
      duty_d  = '0;
    end
    fault_d = (state_d == FAULT);
`endif
    busy_d  = (state_d != IDLE);
    at_d    = (state_d == HOLD);
    // Prescaler restarts on every state change and is held outside SLEW/STOP.
    cnt_clr = (state_d != state_q) || !((state_q == SLEW) || (state_q == STOP));
  end

  pwm_ramp_tick #(.DIV_W(DIV_W)) u_tick (
    .clk  (wb_clk_i),
    .rst  (wb_rst_i),
    .clr  (cnt_clr),
    .div  (div_i),
    .tick (tick)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      duty_q  <= '0;
      busy_q  <= 1'b0;
      at_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      duty_q  <= duty_d;
      busy_q  <= busy_d;
      at_q    <= at_d;
    end
  end

  assign en_o        = en_q;
  assign duty_o      = duty_q;
  assign busy_o      = busy_q;
  assign at_target_o = at_q;
  assign state_o     = state_code(state_q);

endmodule
